// File: rtl/clk_div_int.sv
// Runtime-programmable integer clock divider with pass-through for ratios 0 and 1.
// Define CLK_DIV_ODD_BALANCE_EN to add a falling-edge stage that gives odd ratios a 50% duty cycle.
module clk_div_int #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_period_end
);

    localparam logic [RATIO_WIDTH-1:0] ONE = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};

    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] cnt_q;
    logic                   pos_q;
    logic                   div_mode_q;

    logic [RATIO_WIDTH-1:0] ratio_next;
    logic [RATIO_WIDTH-1:0] cnt_next;
    logic [RATIO_WIDTH-1:0] cnt_plus;
    logic [RATIO_WIDTH-1:0] half;
    logic                   pos_next;
    logic                   div_mode_next;
    logic                   load;
    logic                   period_end_next;
    logic                   phase;

    assign half     = ratio_q >> 1;
    assign cnt_plus = cnt_q + ONE;

    // A new ratio is only accepted on a period boundary, while idle, or when the enable drops.
    assign load = !div_mode_q || (cnt_q == ratio_q - ONE) || !i_clk_en;

    always_comb begin
        ratio_next    = ratio_q;
        div_mode_next = div_mode_q;
        cnt_next      = cnt_q;
        pos_next      = pos_q;
        if (load) begin
            ratio_next    = i_div_ratio;
            div_mode_next = i_clk_en && (i_div_ratio > ONE);
            cnt_next      = '0;
            pos_next      = i_clk_en && (i_div_ratio > ONE);
        end else begin
            cnt_next = cnt_plus;
            pos_next = (cnt_plus < half);
        end
    end

    assign period_end_next = div_mode_next && (cnt_next == ratio_next - ONE);

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            ratio_q      <= '0;
            cnt_q        <= '0;
            pos_q        <= 1'b0;
            div_mode_q   <= 1'b0;
            o_period_end <= 1'b0;
        end else begin
            ratio_q      <= ratio_next;
            cnt_q        <= cnt_next;
            pos_q        <= pos_next;
            div_mode_q   <= div_mode_next;
            o_period_end <= period_end_next;
        end
    end

`ifdef CLK_DIV_ODD_BALANCE_EN
    logic neg_q;

    // Half-cycle delayed copy of the phase stretches the high time by half a reference period.
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign phase = ratio_q[0] ? (pos_q | neg_q) : pos_q;
`else
    assign phase = pos_q;
`endif

    assign o_div_clk = div_mode_q ? phase : i_ref_clk;

endmodule

// File: tb/tb_clk_div_int.sv
// Directed self-checking bench for clk_div_int; honours CLK_DIV_ODD_BALANCE_EN when defined.
module tb_clk_div_int;

    localparam int RW = 8;

    logic          ref_clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [RW-1:0] div_ratio;
    logic          div_clk;
    logic          period_end;

    int checks = 0;
    int errors = 0;

    clk_div_int #(.RATIO_WIDTH(RW)) dut (
        .i_ref_clk    (ref_clk),
        .i_rst        (rst),
        .i_clk_en     (clk_en),
        .i_div_ratio  (div_ratio),
        .o_div_clk    (div_clk),
        .o_period_end (period_end)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [RW-1:0] ratio, input logic en);
        div_ratio = ratio;
        clk_en    = en;
    endtask

    // Sample just after the falling edge, where the output shows the registered phase only.
    task automatic tick();
        @(posedge ref_clk);
        #6;
    endtask

    task automatic tickRise();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_div, input logic exp_pe);
        cmp({tag, "_div"}, {31'd0, div_clk}, {31'd0, exp_div});
        cmp({tag, "_pe"}, {31'd0, period_end}, {31'd0, exp_pe});
    endtask

    task automatic checkPeriods(input string tag, input int n, input int count);
        for (int i = 0; i < n * count; i++) begin
            int c;
            c = i % n;
            tick();
            checkOutput($sformatf("%s_c%0d", tag, c), c < n / 2, c == n - 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(8'd4, 1'b1);

        // Reset held: output must follow the reference clock in both phases.
        for (int i = 0; i < 3; i++) begin
            tickRise();
            cmp("rst_div_high", {31'd0, div_clk}, 32'd1);
            cmp("rst_pe", {31'd0, period_end}, 32'd0);
            #5;
            cmp("rst_div_low", {31'd0, div_clk}, 32'd0);
        end
        #1;
        rst = 1'b0;

        checkPeriods("n4", 4, 2);

        applyStimulus(8'd5, 1'b1);
        checkPeriods("n5", 5, 2);
`ifdef CLK_DIV_ODD_BALANCE_EN
        for (int c = 0; c < 5; c++) begin
            tickRise();
            cmp($sformatf("n5bal_rise_c%0d", c), {31'd0, div_clk}, {31'd0, c < 3});
        end
`endif

        // Ratio changes mid-period are ignored; the value present at the boundary wins.
        applyStimulus(8'd6, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput($sformatf("n6_c%0d", c), c < 3, c == 5);
            if (c == 1) applyStimulus(8'd7, 1'b1);
            if (c == 2) applyStimulus(8'd3, 1'b1);
        end
        checkPeriods("n3", 3, 2);

        applyStimulus(8'd8, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("n8_c%0d", c), 1'b1, 1'b0);
        end
        applyStimulus(8'd8, 1'b0);
        tick();
        checkOutput("en_off", 1'b0, 1'b0);
        cmp("en_off_cnt", 32'(dut.cnt_q), 32'd0);
        cmp("en_off_pos", {31'd0, dut.pos_q}, 32'd0);
        cmp("en_off_mode", {31'd0, dut.div_mode_q}, 32'd0);
        tickRise();
        cmp("en_off_rise", {31'd0, div_clk}, 32'd1);
        applyStimulus(8'd8, 1'b1);
        checkPeriods("n8_reen", 8, 1);

        applyStimulus(8'd0, 1'b1);
        tick();
        checkOutput("n0_low", 1'b0, 1'b0);
        tickRise();
        cmp("n0_rise", {31'd0, div_clk}, 32'd1);
        cmp("n0_pe", {31'd0, period_end}, 32'd0);
        applyStimulus(8'd1, 1'b1);
        tick();
        checkOutput("n1_low", 1'b0, 1'b0);
        tickRise();
        cmp("n1_rise", {31'd0, div_clk}, 32'd1);
        cmp("n1_pe", {31'd0, period_end}, 32'd0);

        applyStimulus(8'd255, 1'b1);
        checkPeriods("n255", 255, 1);
        cmp("n255_cnt_end", 32'(dut.cnt_q), 32'd254);

        // Async reset while the divided clock is high and the reference clock is low.
        applyStimulus(8'd10, 1'b1);
        checkPeriods("n10", 10, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("n10b_c%0d", c), 1'b1, 1'b0);
        end
        rst = 1'b1;
        #1;
        cmp("async_rst_div", {31'd0, div_clk}, 32'd0);
        cmp("async_rst_pe", {31'd0, period_end}, 32'd0);
        cmp("async_rst_ratio", 32'(dut.ratio_q), 32'd0);
        cmp("async_rst_cnt", 32'(dut.cnt_q), 32'd0);
        cmp("async_rst_pos", {31'd0, dut.pos_q}, 32'd0);
        cmp("async_rst_mode", {31'd0, dut.div_mode_q}, 32'd0);
`ifdef CLK_DIV_ODD_BALANCE_EN
        cmp("async_rst_neg", {31'd0, dut.neg_q}, 32'd0);
`endif
        tickRise();
        cmp("async_rst_follow", {31'd0, div_clk}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
